vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA sync/timing generator for the digit-display path: derives a pixel
//  tick from the system clock and produces hSync, vSync, active, x/y pixel coordinates
//  and line/frame start strobes. Front porch, sync, back porch, polarity and divider are
//  all configurable. Pixel renderers (digit ROM, colour mux) sit downstream on x/y/active.
// PARAMETERS
//  CLK_DIV   4    system clocks per pixel (>=1); 100 MHz -> 25 MHz pixel
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hSync asserted level (0 = active-low)
//  VS_POL    0    vSync asserted level
//  X_W, Y_W  10   coordinate widths; elaboration $error if 2**X_W < H_TOTAL or 2**Y_W < V_TOTAL
// PORTS
//  clk         in   1    system clock
//  reset       in   1    synchronous, active-high reset
//  en          in   1    1 = run; 0 = freeze divider, counters and all outputs
//  pixTick     out  1    1-clk strobe: counters advance on this edge
//  hSync       out  1    horizontal sync, level per HS_POL
//  vSync       out  1    vertical sync, level per VS_POL
//  active      out  1    current pixel inside visible area
//  x           out  X_W  pixel column when active, else 0
//  y           out  Y_W  pixel row when active, else 0
//  lineStart   out  1    1-clk pulse: outputs now show hCnt==0
//  frameStart  out  1    1-clk pulse: outputs now show hCnt==0, vCnt==0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//  - divCnt counts 0..CLK_DIV-1 when en=1; pixTick = en && divCnt==CLK_DIV-1 (combinational).
//  - On pixTick: hCnt wraps H_TOTAL-1 -> 0, else +1; on hCnt wrap, vCnt wraps V_TOTAL-1 -> 0, else +1.
//  - Regions (per axis): active [0,ACT-1], FP [ACT,ACT+FP-1], sync [ACT+FP,ACT+FP+SYNC-1], BP rest.
//  - vSync decoded from vCnt only; it changes on the same edge as the hCnt 0 transition.
//  - All outputs except pixTick are registered decodes of (hCnt,vCnt): 1-clk lag behind counter update,
//    stable for the remaining CLK_DIV-1 clks of the pixel.
//  - lineStart/frameStart pulse exactly one clk, in the first clk the outputs show the new position
//    (clk after the counter update, or first clk after reset release).
//  - reset (wins over en): divCnt=hCnt=vCnt=0; hSync=~HS_POL, vSync=~VS_POL, active=0, x=0, y=0,
//    lineStart=0, frameStart=0. First clk after release: decode of (0,0) -> active=1, x=y=0,
//    lineStart=1, frameStart=1.
//  - Reset mid-frame: abandons the frame; no partial-frame completion, next frame starts at (0,0).
//  - en=0: no state changes, outputs hold, strobes held 0; resumes at the same divCnt.
//  - Zero-width porch parameters are legal; sync widths must be >=1 (elaboration $error otherwise).
// TESTING
//  Small config unless stated: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), CLK_DIV=2, polarities 0.
//  1. reset 3 clks -> hSync=1,vSync=1,active=0,x=y=0; 1st clk after release frameStart=lineStart=1, active=1.
//  2. free-run -> lineStart every 16 clks; hSync low exactly 4 clks from hCnt=5; x=0..3 then 0 while inactive.
//  3. free-run -> frameStart every 96 clks; vSync low 16 clks during vCnt=4; y=0..2 in active lines only.
//  4. en=0 for 7 clks mid-line -> all outputs frozen, no strobes; that line period becomes 23 clks.
//  5. reset at vCnt=2,hCnt=3 -> reset values next clk; frameStart 1 clk after release; next frame 96 clks.
//  6. defaults, CLK_DIV=4 -> lineStart spacing 3200 clks, frameStart spacing 1,680,000, active 2560 clks/line.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/timing generator with pixel-tick divider
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   en         run enable; 0 freezes divider, counters and outputs
//   pixTick    combinational strobe, counters advance on the following edge
//   hSync      horizontal sync at HS_POL level during the sync region
//   vSync      vertical sync at VS_POL level during the sync lines
//   active     pixel inside the visible area
//   x, y       pixel coordinates when active, else 0
//   lineStart  one-clk pulse when outputs first show hCnt==0
//   frameStart one-clk pulse when outputs first show hCnt==0, vCnt==0
module vga_timing_gen #(
   parameter int   CLK_DIV  = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   X_W      = 10,
   parameter int   Y_W      = 10
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   output logic           pixTick,
   output logic           hSync,
   output logic           vSync,
   output logic           active,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           lineStart,
   output logic           frameStart
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end
   if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be >= 1");
   end
   if ((2 ** X_W) < H_TOTAL || (2 ** Y_W) < V_TOTAL) begin : g_bad_width
      $error("vga_timing_gen: coordinate width too small for total line/frame size");
   end
   logic [DW-1:0]  div;
   logic [X_W-1:0] h;
   logic [Y_W-1:0] v;
   // set by the edge that moved the counters, so the next registered decode can strobe
   logic fresh;
   logic act_n, hs_n, vs_n;
   assign pixTick = en && div == DIV_LAST;
   always_comb begin
      act_n = int'(h) < H_ACTIVE && int'(v) < V_ACTIVE;
      hs_n  = int'(h) >= H_ACTIVE + H_FP && int'(h) < H_ACTIVE + H_FP + H_SYNC;
      vs_n  = int'(v) >= V_ACTIVE + V_FP && int'(v) < V_ACTIVE + V_FP + V_SYNC;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         div        <= '0;
         h          <= '0;
         v          <= '0;
         fresh      <= 1'b1;
         hSync      <= ~HS_POL;
         vSync      <= ~VS_POL;
         active     <= 1'b0;
         x          <= '0;
         y          <= '0;
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end else if (en) begin
         div <= pixTick ? '0 : div + 1'b1;
         if (pixTick) begin
            h <= (h == H_LAST) ? '0 : h + 1'b1;
            if (h == H_LAST) v <= (v == V_LAST) ? '0 : v + 1'b1;
         end
         fresh      <= pixTick;
         hSync      <= hs_n ? HS_POL : ~HS_POL;
         vSync      <= vs_n ? VS_POL : ~VS_POL;
         active     <= act_n;
         x          <= act_n ? h : '0;
         y          <= act_n ? v : '0;
         lineStart  <= fresh && h == '0;
         frameStart <= fresh && h == '0 && v == '0;
      end else begin
         lineStart  <= 1'b0;
         frameStart <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator (small config plus defaults)
module tb_vga_timing_gen;
   logic clk, reset, en, reset_d;
   logic pixTick, hSync, vSync, active, lineStart, frameStart;
   logic [3:0] x, y;
   logic dd_pt, dd_hs, dd_vs, dd_act, dd_ls, dd_fs;
   logic [9:0] dd_x, dd_y;
   int passed, total, e, clk_n, last_ls, last_fs, ls_period, fs_period, hs_low, vs_low;
   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .X_W(4), .Y_W(4)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .pixTick(pixTick), .hSync(hSync), .vSync(vSync),
      .active(active), .x(x), .y(y), .lineStart(lineStart), .frameStart(frameStart)
   );
   vga_timing_gen dd (
      .clk(clk), .reset(reset_d), .en(1'b1), .pixTick(dd_pt), .hSync(dd_hs), .vSync(dd_vs),
      .active(dd_act), .x(dd_x), .y(dd_y), .lineStart(dd_ls), .frameStart(dd_fs)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s e=%0d obs=%0d exp=%0d", tag, e, obs, exp);
   endtask
   // expected small-config outputs after e enabled edges since reset release
   task automatic check_model(input bit frozen);
      int p, h, v;
      bit act;
      p = (e - 1) / 2;
      h = p % 8;
      v = (p / 8) % 6;
      act = h < 4 && v < 3;
      chk("active", active, act);
      chk("x", x, act ? h : 0);
      chk("y", y, act ? v : 0);
      chk("hSync", hSync, !(h == 5 || h == 6));
      chk("vSync", vSync, v != 4);
      chk("lineStart", lineStart, !frozen && (e - 1) % 16 == 0);
      chk("frameStart", frameStart, !frozen && (e - 1) % 96 == 0);
      chk("pixTick", pixTick, !frozen && e % 2 == 1);
   endtask
   task automatic check_reset();
      chk("rst_hSync", hSync, 1);
      chk("rst_vSync", vSync, 1);
      chk("rst_active", active, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_lineStart", lineStart, 0);
      chk("rst_frameStart", frameStart, 0);
   endtask
   task automatic step(input bit model);
      bit en_was, rst_was;
      en_was = en;
      rst_was = reset;
      @(posedge clk);
      #1;
      clk_n++;
      if (rst_was) e = 0;
      else if (en_was) e++;
      if (lineStart) begin
         ls_period = clk_n - last_ls;
         last_ls = clk_n;
      end
      if (frameStart) begin
         fs_period = clk_n - last_fs;
         last_fs = clk_n;
      end
      hs_low += int'(!hSync);
      vs_low += int'(!vSync);
      if (model) check_model(!en_was);
   endtask
   initial begin
      int n_ls, t_first, per, act_cnt;
      passed = 0; total = 0; e = 0; clk_n = 0;
      last_ls = 0; last_fs = 0; ls_period = 0; fs_period = 0;
      reset = 1'b1; en = 1'b1; reset_d = 1'b1;
      repeat (3) step(0);
      check_reset();
      reset = 1'b0;
      hs_low = 0; vs_low = 0;
      repeat (16) step(1);
      chk("hs_low_clks", hs_low, 4);
      step(1);
      chk("line_period", ls_period, 16);
      repeat (79) step(1);
      chk("vs_low_clks", vs_low, 16);
      step(1);
      chk("frame_period", fs_period, 96);
      repeat (3) step(1);
      en = 1'b0;
      repeat (7) step(1);
      en = 1'b1;
      repeat (13) step(1);
      chk("line_period_frozen", ls_period, 23);
      while (e < 231) step(1);
      chk("pre_reset_x", x, 3);
      chk("pre_reset_y", y, 2);
      reset = 1'b1;
      step(0);
      check_reset();
      reset = 1'b0;
      step(1);
      chk("frameStart_after_reset", frameStart, 1);
      repeat (96) step(1);
      chk("frame_period_after_reset", fs_period, 96);
      reset_d = 1'b0;
      n_ls = 0; t_first = 0; per = 0; act_cnt = 0;
      for (int i = 0; i < 8000 && n_ls < 2; i++) begin
         @(posedge clk);
         #1;
         if (dd_ls) begin
            if (n_ls == 0) t_first = i;
            else per = i - t_first;
            n_ls++;
         end
         if (n_ls == 1) act_cnt += int'(dd_act);
      end
      chk("dflt_two_lines_seen", n_ls, 2);
      chk("dflt_line_period", per, 3200);
      chk("dflt_active_clks", act_cnt, 2560);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
